// File: rtl/rx_lane_byte_packer_pkg.sv
// Shared constants and helpers for the receive-lane byte packer.
package rx_lane_byte_packer_pkg;

    localparam int unsigned IN_BYTES_MAX = 64;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned CNT_W        = 7;

    // Generation selector encodings shared with the lane-width controller.
    localparam logic [1:0] GEN1 = 2'd0;
    localparam logic [1:0] GEN2 = 2'd1;
    localparam logic [1:0] GEN3 = 2'd2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = v - 1;
        while (x != 0) begin
            x = x >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_lane_byte_packer_valid_run_counter.sv
// Counts consecutive ones in the byte-valid mask starting at bit 0.
module valid_run_counter
    import rx_lane_byte_packer_pkg::*;
(
    input  logic [IN_BYTES_MAX-1:0] valid,
    output logic [CNT_W-1:0]        run_len_c
);

    logic run;

    // Once a zero is seen, every higher bit is ignored.
    always_comb begin
        run       = 1'b1;
        run_len_c = '0;
        for (int i = 0; i < int'(IN_BYTES_MAX); i++) begin
            run       = run & valid[i];
            run_len_c = run_len_c + CNT_W'(run);
        end
    end

endmodule

// File: rtl/rx_lane_byte_packer.sv
// Compacts valid lane bytes into a circular buffer and emits fixed-width
// words with a valid/ready handshake; flushes on link-down.
module rx_lane_byte_packer
    import rx_lane_byte_packer_pkg::*;
#(
    parameter int unsigned IN_BYTES     = 64,
    parameter int unsigned OUT_BYTES    = 16,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned AFULL_MARGIN = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w,
    input  logic [IN_BYTES_MAX-1:0]       valid,
    input  logic [BYTE_W*IN_BYTES-1:0]    data_in,
    input  logic                          linkup,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [BYTE_W*OUT_BYTES-1:0]   out_data,
    output logic [clog2(DEPTH):0]         occupancy,
    output logic                          almost_full,
    output logic                          overflow
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned IDX_W = clog2(IN_BYTES);

    logic [BYTE_W-1:0]            mem [DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             wr_cnt_c;
    logic [PTR_W-1:0]             rd_next_c;
    logic [OCC_W-1:0]             free_c;
    logic [OCC_W-1:0]             occ_pop_c;
    logic [OCC_W-1:0]             occ_next_c;
    logic                         fits_c;
    logic                         accept_c;
    logic                         drop_c;
    logic                         pop_c;
    logic [PTR_W-1:0]             off_c [DEPTH];
    logic [DEPTH-1:0]             mem_we_c;
    logic [BYTE_W-1:0]            mem_wd_c [DEPTH];
    logic [BYTE_W*OUT_BYTES-1:0]  word_c;

    valid_run_counter u_run (
        .valid     (valid),
        .run_len_c (wr_cnt_c)
    );

    // Accept/drop decision uses the registered occupancy, ignoring a same-cycle pop.
    always_comb begin
        free_c     = OCC_W'(DEPTH) - occupancy;
        fits_c     = OCC_W'(wr_cnt_c) <= free_c;
        accept_c   = w & linkup & (wr_cnt_c != '0) & fits_c;
        drop_c     = w & linkup & (wr_cnt_c != '0) & ~fits_c;
        pop_c      = out_valid & out_ready & linkup;
        rd_next_c  = pop_c ? rd_ptr + PTR_W'(OUT_BYTES) : rd_ptr;
        occ_pop_c  = pop_c ? occupancy - OCC_W'(OUT_BYTES) : occupancy;
        occ_next_c = occ_pop_c + (accept_c ? OCC_W'(wr_cnt_c) : OCC_W'(0));
    end

    // Per-entry write enable: entry j takes input byte (j - wr_ptr) mod DEPTH.
    always_comb begin
        for (int j = 0; j < int'(DEPTH); j++) begin
            off_c[j]    = PTR_W'(j) - wr_ptr;
            mem_we_c[j] = accept_c & ({1'b0, off_c[j]} < OCC_W'(wr_cnt_c));
            mem_wd_c[j] = data_in[BYTE_W*off_c[j][IDX_W-1:0] +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (mem_we_c[j]) begin
                mem[j] <= mem_wd_c[j];
            end
        end
    end

    // Output window starts at the post-pop read pointer and wraps at the buffer end.
    always_comb begin
        word_c = '0;
        for (int k = 0; k < int'(OUT_BYTES); k++) begin
            word_c[BYTE_W*k +: BYTE_W] = mem[rd_next_c + PTR_W'(k)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else if (!linkup) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(wr_cnt_c);
            end
            rd_ptr      <= rd_next_c;
            occupancy   <= occ_next_c;
            // Bytes written on this edge become visible one cycle later.
            out_valid   <= occ_pop_c >= OCC_W'(OUT_BYTES);
            out_data    <= word_c;
            almost_full <= (OCC_W'(DEPTH) - occ_next_c) < OCC_W'(AFULL_MARGIN);
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
